// File: rtl/ar_voice_allocator_pkg.sv
// ar_voice_allocator_pkg: FSM states, voice-choice codes and shared defaults
package ar_voice_allocator_pkg;
  localparam int NOTEBITS_DEF = 7;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_APPLY} state_t;
  typedef enum logic [1:0] {DEC_NONE, DEC_MATCH, DEC_FREE, DEC_STEAL} dec_t;
endpackage

// File: rtl/ar_voice_slot.sv
// ar_voice_slot: one AR voice's gate, note, age and retrigger-gap state
//  do_assign  : take new_note, open gate at once (free voice)
//  do_retrig  : take new_note, hold gate low RETRIG_GAP clocks then open
//  do_release : close gate and cancel any pending gap
//  panic      : close gate, clear gap and age
//  gate/note/age : voice state; active = gate open or gap pending
module ar_voice_slot
  import ar_voice_allocator_pkg::*;
#(
  parameter int NOTEBITS   = NOTEBITS_DEF,
  parameter int AGEBITS    = 8,
  parameter int RETRIG_GAP = 2
) (
  input  logic                sample_clock,
  input  logic                reset_n,
  input  logic                do_assign,
  input  logic                do_retrig,
  input  logic                do_release,
  input  logic                panic,
  input  logic [NOTEBITS-1:0] new_note,
  output logic                gate,
  output logic                active,
  output logic [NOTEBITS-1:0] note,
  output logic [AGEBITS-1:0]  age
);
  localparam int GW = $clog2(RETRIG_GAP + 1);
  logic                gate_q, gate_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [AGEBITS-1:0]  age_q, age_d;
  logic [NOTEBITS-1:0] note_q, note_d;
  always_comb begin
    gate_d = gate_q | (gap_q == GW'(1));
    gap_d  = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
    age_d  = (gate_q && age_q != '1) ? age_q + AGEBITS'(1) : age_q;
    note_d = note_q;
    if (panic) begin
      gate_d = 1'b0;
      gap_d  = '0;
      age_d  = '0;
    end else if (do_assign) begin
      note_d = new_note;
      gate_d = 1'b1;
      age_d  = '0;
    end else if (do_retrig) begin
      note_d = new_note;
      gate_d = 1'b0;
      gap_d  = GW'(RETRIG_GAP);
      age_d  = '0;
    end else if (do_release) begin
      gate_d = 1'b0;
      gap_d  = '0;
    end
  end
  always_ff @(posedge sample_clock or negedge reset_n) begin
    if (!reset_n) begin
      gate_q <= 1'b0;
      gap_q  <= '0;
      age_q  <= '0;
      note_q <= '0;
    end else begin
      gate_q <= gate_d;
      gap_q  <= gap_d;
      age_q  <= age_d;
      note_q <= note_d;
    end
  end
  assign gate   = gate_q;
  assign active = gate_q | (gap_q != '0);
  assign note   = note_q;
  assign age    = age_q;
endmodule

// File: rtl/ar_voice_allocator.sv
// ar_voice_allocator: assigns note-on/off events to NVOICES AR voices (match, free or steal oldest)
//  evt_valid/evt_ready/evt_note_on/evt_note : event handshake
//  panic       : synchronous all-notes-off, discards in-flight event
//  gate        : per-voice gate
//  voice_note  : voice i at [i*NOTEBITS +: NOTEBITS]
//  steal_pulse : one clock when an active voice is taken over
module ar_voice_allocator
  import ar_voice_allocator_pkg::*;
#(
  parameter int NVOICES    = 4,
  parameter int NOTEBITS   = NOTEBITS_DEF,
  parameter int AGEBITS    = 8,
  parameter int RETRIG_GAP = 2
) (
  input  logic                        sample_clock,
  input  logic                        reset_n,
  input  logic                        evt_valid,
  output logic                        evt_ready,
  input  logic                        evt_note_on,
  input  logic [NOTEBITS-1:0]         evt_note,
  input  logic                        panic,
  output logic [NVOICES-1:0]          gate,
  output logic [NVOICES*NOTEBITS-1:0] voice_note,
  output logic                        steal_pulse
);
  localparam int IW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
  state_t              state_q, state_d;
  dec_t                dec_q, dec_d;
  logic [IW-1:0]       idx_q, idx_d, sel_q, sel_d;
  logic [AGEBITS-1:0]  best_q, best_d;
  logic                on_q, on_d, steal_q, steal_d, rdy_q, rdy_d;
  logic [NOTEBITS-1:0] note_q, note_d;
  logic [NOTEBITS-1:0] notes [NVOICES];
  logic [AGEBITS-1:0]  ages [NVOICES];
  logic [NVOICES-1:0]  active;
  logic                act_i, eq_i, older, apply, open_slot;
  // rdy_q keeps evt_ready low until the first clock after reset release
  assign evt_ready   = rdy_q && state_q == ST_IDLE && !panic;
  assign apply       = state_q == ST_APPLY && !panic;
  assign act_i       = active[idx_q];
  assign eq_i        = notes[idx_q] == note_q;
  assign older       = dec_q == DEC_NONE || ages[idx_q] > best_q;
  // a FREE or MATCH already found outranks any steal candidate
  assign open_slot   = dec_q == DEC_NONE || dec_q == DEC_STEAL;
  assign steal_pulse = steal_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    sel_d   = sel_q;
    best_d  = best_q;
    on_d    = on_q;
    note_d  = note_q;
    rdy_d   = 1'b1;
    steal_d = apply && dec_q == DEC_STEAL;
    if (panic) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      if (evt_valid && evt_ready) begin
        state_d = ST_SCAN;
        idx_d   = '0;
        dec_d   = DEC_NONE;
        best_d  = '0;
        on_d    = evt_note_on;
        note_d  = evt_note;
      end
    end else if (state_q == ST_SCAN) begin
      idx_d   = idx_q + IW'(1);
      state_d = (idx_q == IW'(NVOICES - 1)) ? ST_APPLY : ST_SCAN;
      if (on_q) begin
        if (act_i && eq_i && dec_q != DEC_MATCH) begin
          dec_d = DEC_MATCH;
          sel_d = idx_q;
        end else if (!act_i && open_slot) begin
          dec_d = DEC_FREE;
          sel_d = idx_q;
        end else if (act_i && open_slot && older) begin
          dec_d  = DEC_STEAL;
          sel_d  = idx_q;
          best_d = ages[idx_q];
        end
      end else if (act_i && eq_i && dec_q == DEC_NONE) begin
        dec_d = DEC_MATCH;
        sel_d = idx_q;
      end
    end else begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge sample_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dec_q   <= DEC_NONE;
      sel_q   <= '0;
      best_q  <= '0;
      on_q    <= 1'b0;
      note_q  <= '0;
      steal_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      sel_q   <= sel_d;
      best_q  <= best_d;
      on_q    <= on_d;
      note_q  <= note_d;
      steal_q <= steal_d;
      rdy_q   <= rdy_d;
    end
  end
  for (genvar v = 0; v < NVOICES; v++) begin : g_slot
    ar_voice_slot #(
      .NOTEBITS  (NOTEBITS),
      .AGEBITS   (AGEBITS),
      .RETRIG_GAP(RETRIG_GAP)
    ) u_slot (
      .sample_clock(sample_clock),
      .reset_n     (reset_n),
      .do_assign   (apply && sel_q == IW'(v) && dec_q == DEC_FREE),
      .do_retrig   (apply && sel_q == IW'(v) && (dec_q == DEC_STEAL || (dec_q == DEC_MATCH && on_q))),
      .do_release  (apply && sel_q == IW'(v) && dec_q == DEC_MATCH && !on_q),
      .panic       (panic),
      .new_note    (note_q),
      .gate        (gate[v]),
      .active      (active[v]),
      .note        (notes[v]),
      .age         (ages[v])
    );
    assign voice_note[v*NOTEBITS +: NOTEBITS] = notes[v];
  end
endmodule

// File: tb/tb_ar_voice_allocator.sv
// tb_ar_voice_allocator: directed scenario checks of the voice allocator
module tb_ar_voice_allocator;
  localparam int NV = 4;
  localparam int NB = 7;
  logic sample_clock = 1'b0;
  logic reset_n = 1'b1;
  logic evt_valid = 1'b0;
  logic evt_note_on = 1'b0;
  logic panic = 1'b0;
  logic [NB-1:0] evt_note = '0;
  logic evt_ready, steal_pulse, ready_g, steal_g;
  logic [NV-1:0] gate, gate_g;
  logic [NV*NB-1:0] voice_note, note_g;
  int checks = 0;
  int errors = 0;
  always #5 sample_clock = ~sample_clock;
  ar_voice_allocator #(.NVOICES(NV), .NOTEBITS(NB), .AGEBITS(8), .RETRIG_GAP(2)) dut (
    .sample_clock(sample_clock), .reset_n(reset_n), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_note_on(evt_note_on), .evt_note(evt_note), .panic(panic), .gate(gate),
    .voice_note(voice_note), .steal_pulse(steal_pulse)
  );
  // long-gap twin, fed the same events, makes a note-off inside the gap reachable
  ar_voice_allocator #(.NVOICES(NV), .NOTEBITS(NB), .AGEBITS(8), .RETRIG_GAP(10)) dut_g (
    .sample_clock(sample_clock), .reset_n(reset_n), .evt_valid(evt_valid), .evt_ready(ready_g),
    .evt_note_on(evt_note_on), .evt_note(evt_note), .panic(panic), .gate(gate_g),
    .voice_note(note_g), .steal_pulse(steal_g)
  );
  task automatic send(input logic on, input logic [NB-1:0] n);
    int k = 0;
    @(negedge sample_clock);
    while (!evt_ready && k < 50) begin
      @(negedge sample_clock);
      k++;
    end
    checks++;
    if (evt_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready_timeout: evt_ready=%b expected 1", evt_ready);
    end
    evt_valid = 1'b1;
    evt_note_on = on;
    evt_note = n;
    @(posedge sample_clock);
    #1 evt_valid = 1'b0;
  endtask
  task automatic wait_apply();
    repeat (NV + 1) @(posedge sample_clock);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge sample_clock);
    @(negedge sample_clock) reset_n = 1'b1;
    @(posedge sample_clock);
    #1;
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if (gate !== 4'b0000) begin errors++; $display("FAIL reset_gate: got %b expected 0000", gate); end
    checks++;
    if (voice_note !== 28'h0) begin errors++; $display("FAIL reset_note: got %h expected 0", voice_note); end
    checks++;
    if (steal_pulse !== 1'b0) begin errors++; $display("FAIL reset_steal: got %b expected 0", steal_pulse); end
    checks++;
    if (evt_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", evt_ready); end
    repeat (2) @(posedge sample_clock);
    @(negedge sample_clock) reset_n = 1'b1;
    #1;
    checks++;
    if (evt_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b expected 0", evt_ready); end
    @(posedge sample_clock);
    #1;
    checks++;
    if (evt_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %b expected 1", evt_ready); end
  endtask
  task automatic test_note_on();
    send(1'b1, 7'd60);
    repeat (NV) @(posedge sample_clock);
    #1;
    checks++;
    if (gate !== 4'b0000) begin errors++; $display("FAIL early_gate: got %b expected 0000", gate); end
    checks++;
    if (evt_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b expected 0", evt_ready); end
    @(posedge sample_clock);
    #1;
    checks++;
    if (gate !== 4'b0001) begin errors++; $display("FAIL first_gate: got %b expected 0001", gate); end
    checks++;
    if (voice_note[6:0] !== 7'd60) begin errors++; $display("FAIL first_note: got %0d expected 60", voice_note[6:0]); end
    checks++;
    if (evt_ready !== 1'b1) begin errors++; $display("FAIL first_ready: got %b expected 1", evt_ready); end
  endtask
  task automatic test_steal();
    send(1'b1, 7'd62); wait_apply();
    send(1'b1, 7'd64); wait_apply();
    send(1'b1, 7'd65); wait_apply();
    checks++;
    if (gate !== 4'b1111) begin errors++; $display("FAIL fill_gate: got %b expected 1111", gate); end
    checks++;
    if (voice_note !== {7'd65, 7'd64, 7'd62, 7'd60}) begin errors++; $display("FAIL fill_note: got %h expected %h", voice_note, {7'd65, 7'd64, 7'd62, 7'd60}); end
    send(1'b1, 7'd67); wait_apply();
    checks++;
    if (steal_pulse !== 1'b1) begin errors++; $display("FAIL steal_pulse: got %b expected 1", steal_pulse); end
    checks++;
    if (gate !== 4'b1110) begin errors++; $display("FAIL steal_gate0: got %b expected 1110", gate); end
    checks++;
    if (voice_note !== {7'd65, 7'd64, 7'd62, 7'd67}) begin errors++; $display("FAIL steal_note: got %h expected %h", voice_note, {7'd65, 7'd64, 7'd62, 7'd67}); end
    @(posedge sample_clock);
    #1;
    checks++;
    if (steal_pulse !== 1'b0) begin errors++; $display("FAIL steal_pulse_len: got %b expected 0", steal_pulse); end
    checks++;
    if (gate !== 4'b1110) begin errors++; $display("FAIL steal_gate1: got %b expected 1110", gate); end
    @(posedge sample_clock);
    #1;
    checks++;
    if (gate !== 4'b1111) begin errors++; $display("FAIL steal_gate2: got %b expected 1111", gate); end
  endtask
  task automatic test_retrigger();
    send(1'b1, 7'd67); wait_apply();
    checks++;
    if (steal_pulse !== 1'b0) begin errors++; $display("FAIL retrig_steal: got %b expected 0", steal_pulse); end
    checks++;
    if (gate !== 4'b1110) begin errors++; $display("FAIL retrig_gate0: got %b expected 1110", gate); end
    checks++;
    if (voice_note !== {7'd65, 7'd64, 7'd62, 7'd67}) begin errors++; $display("FAIL retrig_note: got %h expected %h", voice_note, {7'd65, 7'd64, 7'd62, 7'd67}); end
    @(posedge sample_clock);
    #1;
    checks++;
    if (gate !== 4'b1110) begin errors++; $display("FAIL retrig_gate1: got %b expected 1110", gate); end
    @(posedge sample_clock);
    #1;
    checks++;
    if (gate !== 4'b1111) begin errors++; $display("FAIL retrig_gate2: got %b expected 1111", gate); end
  endtask
  task automatic test_note_off();
    send(1'b0, 7'd62); wait_apply();
    checks++;
    if (gate !== 4'b1101) begin errors++; $display("FAIL off_gate: got %b expected 1101", gate); end
    checks++;
    if (voice_note !== {7'd65, 7'd64, 7'd62, 7'd67}) begin errors++; $display("FAIL off_note_hold: got %h expected %h", voice_note, {7'd65, 7'd64, 7'd62, 7'd67}); end
    send(1'b0, 7'd70); wait_apply();
    checks++;
    if (gate !== 4'b1101) begin errors++; $display("FAIL absent_gate: got %b expected 1101", gate); end
    checks++;
    if (voice_note !== {7'd65, 7'd64, 7'd62, 7'd67}) begin errors++; $display("FAIL absent_note: got %h expected %h", voice_note, {7'd65, 7'd64, 7'd62, 7'd67}); end
    checks++;
    if (evt_ready !== 1'b1) begin errors++; $display("FAIL absent_ready: got %b expected 1", evt_ready); end
    send(1'b1, 7'd71); wait_apply();
    checks++;
    if (gate !== 4'b1111) begin errors++; $display("FAIL free_gate: got %b expected 1111", gate); end
    checks++;
    if (voice_note !== {7'd65, 7'd64, 7'd71, 7'd67}) begin errors++; $display("FAIL free_note: got %h expected %h", voice_note, {7'd65, 7'd64, 7'd71, 7'd67}); end
    checks++;
    if (steal_pulse !== 1'b0) begin errors++; $display("FAIL free_steal: got %b expected 0", steal_pulse); end
  endtask
  task automatic test_gap_release();
    do_reset();
    send(1'b1, 7'd60); wait_apply();
    send(1'b1, 7'd60); wait_apply();
    checks++;
    if (gate_g !== 4'b0000) begin errors++; $display("FAIL gap_start: got %b expected 0000", gate_g); end
    send(1'b0, 7'd60); wait_apply();
    checks++;
    if (gate_g !== 4'b0000) begin errors++; $display("FAIL gap_off_gate: got %b expected 0000", gate_g); end
    checks++;
    if (gate !== 4'b0000) begin errors++; $display("FAIL gated_off: got %b expected 0000", gate); end
    checks++;
    if (note_g[6:0] !== 7'd60) begin errors++; $display("FAIL gap_off_note: got %0d expected 60", note_g[6:0]); end
    repeat (12) @(posedge sample_clock);
    #1;
    checks++;
    if (gate_g !== 4'b0000) begin errors++; $display("FAIL gap_expired: got %b expected 0000", gate_g); end
  endtask
  task automatic test_panic();
    do_reset();
    send(1'b1, 7'd60); wait_apply();
    send(1'b1, 7'd62); wait_apply();
    send(1'b1, 7'd64); wait_apply();
    send(1'b1, 7'd65); wait_apply();
    checks++;
    if (gate !== 4'b1111) begin errors++; $display("FAIL panic_fill: got %b expected 1111", gate); end
    send(1'b1, 7'd67);
    repeat (2) @(posedge sample_clock);
    @(negedge sample_clock) panic = 1'b1;
    @(posedge sample_clock);
    #1;
    checks++;
    if (gate !== 4'b0000) begin errors++; $display("FAIL panic_gate: got %b expected 0000", gate); end
    checks++;
    if (evt_ready !== 1'b0) begin errors++; $display("FAIL panic_ready: got %b expected 0", evt_ready); end
    @(negedge sample_clock) panic = 1'b0;
    #1;
    checks++;
    if (evt_ready !== 1'b1) begin errors++; $display("FAIL panic_idle: got %b expected 1", evt_ready); end
    repeat (NV + 2) @(posedge sample_clock);
    #1;
    checks++;
    if (gate !== 4'b0000 || steal_pulse !== 1'b0) begin errors++; $display("FAIL panic_discard: gate=%b steal=%b expected 0000/0", gate, steal_pulse); end
    @(negedge sample_clock);
    evt_valid = 1'b1; evt_note_on = 1'b1; evt_note = 7'd80; panic = 1'b1;
    @(posedge sample_clock);
    #1 evt_valid = 1'b0; panic = 1'b0;
    #1;
    checks++;
    if (evt_ready !== 1'b1) begin errors++; $display("FAIL panic_wins_ready: got %b expected 1", evt_ready); end
    repeat (NV + 1) @(posedge sample_clock);
    #1;
    checks++;
    if (gate !== 4'b0000) begin errors++; $display("FAIL panic_wins_gate: got %b expected 0000", gate); end
  endtask
  task automatic test_async_reset();
    send(1'b1, 7'd70);
    repeat (NV) @(posedge sample_clock);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (gate !== 4'b0000 || voice_note !== 28'h0) begin errors++; $display("FAIL async_outputs: gate=%b note=%h expected 0/0", gate, voice_note); end
    checks++;
    if (evt_ready !== 1'b0 || steal_pulse !== 1'b0) begin errors++; $display("FAIL async_ctrl: ready=%b steal=%b expected 0/0", evt_ready, steal_pulse); end
    @(posedge sample_clock);
    #1;
    checks++;
    if (gate !== 4'b0000) begin errors++; $display("FAIL async_hold: got %b expected 0000", gate); end
    @(negedge sample_clock) reset_n = 1'b1;
    @(posedge sample_clock);
  endtask
  initial begin
    test_reset();
    test_note_on();
    test_steal();
    test_retrigger();
    test_note_off();
    test_gap_release();
    test_panic();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
